// File: rtl/csr_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : csr_access_ctrl_pkg
// Brief    : Shared types and constants for the CSR access controller:
//            CSR op encodings, trap/interrupt cause codes, SYSTEM instruction
//            encodings and the controller state enum.
// Revision : 1.0 - initial release
// ============================================================================
package csr_access_ctrl_pkg;

  // Controller sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // CSR-file operation codes; NONE is driven whenever no CSR access is requested
  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  // Fixed SYSTEM instruction encodings
  localparam logic [31:0] c_inst_ecall  = 32'h0000_0073;
  localparam logic [31:0] c_inst_ebreak = 32'h0010_0073;
  localparam logic [31:0] c_inst_mret   = 32'h3020_0073;

  // CSR read by MRET to obtain the return address
  localparam logic [11:0] c_mepc_addr = 12'h341;

  // Synchronous exception causes
  localparam int c_cause_illegal    = 2;
  localparam int c_cause_breakpoint = 3;
  localparam int c_cause_ecall_m    = 11;

  // Machine interrupt causes
  localparam int c_cause_irq_mei = 11;
  localparam int c_cause_irq_msi = 3;
  localparam int c_cause_irq_mti = 7;

  // Interrupt cause selection: external beats software beats timer
  function automatic int irq_cause_code(input logic meip, input logic msip);
    if (meip) return c_cause_irq_mei;
    if (msip) return c_cause_irq_msi;
    return c_cause_irq_mti;
  endfunction

endpackage
`default_nettype wire

// File: rtl/csr_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : csr_access_ctrl_if
// Brief    : Bundles the execute-stage offer, interrupt lines, CSR-file
//            request/response and the writeback/redirect results of the
//            CSR access controller. Signal directions in the names are seen
//            from the controller; the controller uses the master modport.
// Revision : 1.0 - initial release
// ============================================================================
interface csr_access_ctrl_if #(
  parameter int DATA_W  = 32,
  parameter int CAUSE_W = 4
);

  // Execute-stage offer
  logic               inst_valid_i;
  logic               inst_ready_o;
  logic [31:0]        inst_i;
  logic [DATA_W-1:0]  pc_i;
  logic [DATA_W-1:0]  rs1_data_i;

  // Interrupt lines
  logic               irq_meip_i;
  logic               irq_mtip_i;
  logic               irq_msip_i;
  logic               irq_mie_i;

  // CSR-file request
  logic               csr_is_csr_o;
  logic               csr_is_trap_o;
  logic               csr_is_interrupt_o;
  logic [4:0]         csr_rd_o;
  logic               csr_is_rs1_o;
  logic [DATA_W-1:0]  csr_data_o;
  logic [11:0]        csr_addr_o;
  logic [1:0]         csr_op_o;
  logic [DATA_W-1:0]  csr_pc_o;
  logic [CAUSE_W-1:0] csr_cause_o;

  // CSR-file response
  logic [DATA_W-1:0]  csr_data_i;
  logic               csr_err_i;

  // Results
  logic               wb_valid_o;
  logic [4:0]         wb_rd_o;
  logic [DATA_W-1:0]  wb_data_o;
  logic               redirect_valid_o;
  logic [DATA_W-1:0]  redirect_pc_o;

  modport master (
    input  inst_valid_i, inst_i, pc_i, rs1_data_i,
    input  irq_meip_i, irq_mtip_i, irq_msip_i, irq_mie_i,
    input  csr_data_i, csr_err_i,
    output inst_ready_o,
    output csr_is_csr_o, csr_is_trap_o, csr_is_interrupt_o, csr_rd_o, csr_is_rs1_o,
    output csr_data_o, csr_addr_o, csr_op_o, csr_pc_o, csr_cause_o,
    output wb_valid_o, wb_rd_o, wb_data_o, redirect_valid_o, redirect_pc_o
  );

  modport slave (
    output inst_valid_i, inst_i, pc_i, rs1_data_i,
    output irq_meip_i, irq_mtip_i, irq_msip_i, irq_mie_i,
    output csr_data_i, csr_err_i,
    input  inst_ready_o,
    input  csr_is_csr_o, csr_is_trap_o, csr_is_interrupt_o, csr_rd_o, csr_is_rs1_o,
    input  csr_data_o, csr_addr_o, csr_op_o, csr_pc_o, csr_cause_o,
    input  wb_valid_o, wb_rd_o, wb_data_o, redirect_valid_o, redirect_pc_o
  );

endinterface
`default_nettype wire

// File: rtl/csr_access_ctrl_sys_decode.sv
`default_nettype none
// ============================================================================
// Module   : csr_sys_decode
// Brief    : Combinational SYSTEM-instruction decoder. Maps a raw instruction
//            word and its rs1 value onto a CSR-file request: a CSR access
//            (including MRET's read of mepc) or a synchronous trap.
// Revision : 1.0 - initial release
// ============================================================================
module csr_sys_decode
  import csr_access_ctrl_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          CAUSE_W   = 4,
  parameter logic [11:0] MEPC_ADDR = c_mepc_addr
) (
  input  logic [31:0]        inst_i,
  input  logic [DATA_W-1:0]  rs1_data_i,
  output logic               is_csr_o,
  output logic               is_trap_o,
  output logic               is_mret_o,
  output logic [4:0]         rd_o,
  output logic               is_rs1_o,
  output logic [DATA_W-1:0]  data_o,
  output logic [11:0]        addr_o,
  output csr_op_e            op_o,
  output logic [CAUSE_W-1:0] cause_o
);

  logic [2:0] w_funct3;
  logic [4:0] w_rs1_field;

  assign w_funct3    = inst_i[14:12];
  assign w_rs1_field = inst_i[19:15];

  // Decode funct3 into register/immediate CSR ops, otherwise match the fixed encodings
  always_comb begin
    is_csr_o  = 1'b0;
    is_trap_o = 1'b0;
    is_mret_o = 1'b0;
    rd_o      = 5'd0;
    is_rs1_o  = 1'b0;
    data_o    = '0;
    addr_o    = 12'd0;
    op_o      = CSR_OP_NONE;
    cause_o   = '0;
    case (w_funct3)
      3'b001, 3'b010, 3'b011: begin
        is_csr_o = 1'b1;
        rd_o     = inst_i[11:7];
        addr_o   = inst_i[31:20];
        op_o     = csr_op_e'(w_funct3[1:0]);
        data_o   = rs1_data_i;
        is_rs1_o = (w_rs1_field == 5'd0);
      end
      3'b101, 3'b110, 3'b111: begin
        is_csr_o = 1'b1;
        rd_o     = inst_i[11:7];
        addr_o   = inst_i[31:20];
        op_o     = csr_op_e'(w_funct3[1:0]);
        data_o   = {{(DATA_W-5){1'b0}}, w_rs1_field};
        is_rs1_o = (w_rs1_field == 5'd0);
      end
      default: begin
        if (inst_i == c_inst_ecall) begin
          is_trap_o = 1'b1;
          cause_o   = CAUSE_W'(c_cause_ecall_m);
        end else if (inst_i == c_inst_ebreak) begin
          is_trap_o = 1'b1;
          cause_o   = CAUSE_W'(c_cause_breakpoint);
        end else if (inst_i == c_inst_mret) begin
          // MRET is a side-effect-free read of mepc; its result becomes the redirect target
          is_csr_o  = 1'b1;
          is_mret_o = 1'b1;
          op_o      = CSR_OP_SET;
          addr_o    = MEPC_ADDR;
          is_rs1_o  = 1'b1;
        end else begin
          is_trap_o = 1'b1;
          cause_o   = CAUSE_W'(c_cause_illegal);
        end
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/csr_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : csr_access_ctrl
// Brief    : Core-side initiator for the machine-mode CSR file. Accepts
//            SYSTEM instructions or takes pending interrupts in IDLE, issues
//            a one-cycle CSR request, consumes the registered response and
//            produces a writeback pulse or a PC redirect pulse.
// Revision : 1.0 - initial release
// ============================================================================
module csr_access_ctrl
  import csr_access_ctrl_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter logic [11:0] MEPC_ADDR = c_mepc_addr,
  parameter int          CAUSE_W   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  csr_access_ctrl_if.master bus
);

  // Decoder view of the offered instruction
  logic               w_dec_is_csr;
  logic               w_dec_is_trap;
  logic               w_dec_is_mret;
  logic [4:0]         w_dec_rd;
  logic               w_dec_is_rs1;
  logic [DATA_W-1:0]  w_dec_data;
  logic [11:0]        w_dec_addr;
  csr_op_e            w_dec_op;
  logic [CAUSE_W-1:0] w_dec_cause;

  logic               w_irq_pending;
  logic [CAUSE_W-1:0] w_irq_cause;
  logic               w_resp_redirect;

  state_e             r_state;

  // Request outputs, only non-zero while in ISSUE
  logic               r_csr_is_csr;
  logic               r_csr_is_trap;
  logic               r_csr_is_interrupt;
  logic [4:0]         r_csr_rd;
  logic               r_csr_is_rs1;
  logic [DATA_W-1:0]  r_csr_data;
  logic [11:0]        r_csr_addr;
  csr_op_e            r_csr_op;
  logic [DATA_W-1:0]  r_csr_pc;
  logic [CAUSE_W-1:0] r_csr_cause;

  // Context carried from accept to RESP
  logic               r_ctx_redirect;
  logic [4:0]         r_ctx_rd;
  logic               r_err;

  // Result pulses
  logic               r_wb_valid;
  logic [4:0]         r_wb_rd;
  logic [DATA_W-1:0]  r_wb_data;
  logic               r_redirect_valid;
  logic [DATA_W-1:0]  r_redirect_pc;

  csr_sys_decode #(
    .DATA_W    (DATA_W),
    .CAUSE_W   (CAUSE_W),
    .MEPC_ADDR (MEPC_ADDR)
  ) u_decode (
    .inst_i     (bus.inst_i),
    .rs1_data_i (bus.rs1_data_i),
    .is_csr_o   (w_dec_is_csr),
    .is_trap_o  (w_dec_is_trap),
    .is_mret_o  (w_dec_is_mret),
    .rd_o       (w_dec_rd),
    .is_rs1_o   (w_dec_is_rs1),
    .data_o     (w_dec_data),
    .addr_o     (w_dec_addr),
    .op_o       (w_dec_op),
    .cause_o    (w_dec_cause)
  );

  assign w_irq_pending   = bus.irq_mie_i & (bus.irq_meip_i | bus.irq_mtip_i | bus.irq_msip_i);
  assign w_irq_cause     = CAUSE_W'(irq_cause_code(bus.irq_meip_i, bus.irq_msip_i));
  assign w_resp_redirect = r_ctx_redirect | r_err | bus.csr_err_i;

  // An interrupt taken in IDLE blocks the same-cycle instruction
  assign bus.inst_ready_o = (r_state == ST_IDLE) & ~w_irq_pending;

  // Sequencer: IDLE -> ISSUE -> RESP -> IDLE with all outputs registered
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state            <= ST_IDLE;
      r_csr_is_csr       <= 1'b0;
      r_csr_is_trap      <= 1'b0;
      r_csr_is_interrupt <= 1'b0;
      r_csr_rd           <= 5'd0;
      r_csr_is_rs1       <= 1'b0;
      r_csr_data         <= '0;
      r_csr_addr         <= 12'd0;
      r_csr_op           <= CSR_OP_NONE;
      r_csr_pc           <= '0;
      r_csr_cause        <= '0;
      r_ctx_redirect     <= 1'b0;
      r_ctx_rd           <= 5'd0;
      r_err              <= 1'b0;
      r_wb_valid         <= 1'b0;
      r_wb_rd            <= 5'd0;
      r_wb_data          <= '0;
      r_redirect_valid   <= 1'b0;
      r_redirect_pc      <= '0;
    end else begin
      r_wb_valid       <= 1'b0;
      r_wb_rd          <= 5'd0;
      r_wb_data        <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_irq_pending) begin
            r_csr_is_interrupt <= 1'b1;
            r_csr_cause        <= w_irq_cause;
            r_csr_pc           <= bus.pc_i;
            r_ctx_redirect     <= 1'b1;
            r_ctx_rd           <= 5'd0;
            r_state            <= ST_ISSUE;
          end else if (bus.inst_valid_i) begin
            r_csr_is_csr   <= w_dec_is_csr;
            r_csr_is_trap  <= w_dec_is_trap;
            r_csr_rd       <= w_dec_rd;
            r_csr_is_rs1   <= w_dec_is_rs1;
            r_csr_data     <= w_dec_data;
            r_csr_addr     <= w_dec_addr;
            r_csr_op       <= w_dec_op;
            r_csr_pc       <= bus.pc_i;
            r_csr_cause    <= w_dec_cause;
            r_ctx_redirect <= w_dec_is_trap | w_dec_is_mret;
            r_ctx_rd       <= w_dec_rd;
            r_state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_err              <= bus.csr_err_i;
          r_csr_is_csr       <= 1'b0;
          r_csr_is_trap      <= 1'b0;
          r_csr_is_interrupt <= 1'b0;
          r_csr_rd           <= 5'd0;
          r_csr_is_rs1       <= 1'b0;
          r_csr_data         <= '0;
          r_csr_addr         <= 12'd0;
          r_csr_op           <= CSR_OP_NONE;
          r_csr_pc           <= '0;
          r_csr_cause        <= '0;
          r_state            <= ST_RESP;
        end
        ST_RESP: begin
          if (w_resp_redirect) begin
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= {bus.csr_data_i[DATA_W-1:2], 2'b00};
          end else if (r_ctx_rd != 5'd0) begin
            r_wb_valid <= 1'b1;
            r_wb_rd    <= r_ctx_rd;
            r_wb_data  <= bus.csr_data_i;
          end
          r_err          <= 1'b0;
          r_ctx_redirect <= 1'b0;
          r_ctx_rd       <= 5'd0;
          r_state        <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.csr_is_csr_o       = r_csr_is_csr;
  assign bus.csr_is_trap_o      = r_csr_is_trap;
  assign bus.csr_is_interrupt_o = r_csr_is_interrupt;
  assign bus.csr_rd_o           = r_csr_rd;
  assign bus.csr_is_rs1_o       = r_csr_is_rs1;
  assign bus.csr_data_o         = r_csr_data;
  assign bus.csr_addr_o         = r_csr_addr;
  assign bus.csr_op_o           = r_csr_op;
  assign bus.csr_pc_o           = r_csr_pc;
  assign bus.csr_cause_o        = r_csr_cause;
  assign bus.wb_valid_o         = r_wb_valid;
  assign bus.wb_rd_o            = r_wb_rd;
  assign bus.wb_data_o          = r_wb_data;
  assign bus.redirect_valid_o   = r_redirect_valid;
  assign bus.redirect_pc_o      = r_redirect_pc;

endmodule
`default_nettype wire

// File: tb/tb_csr_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_access_ctrl
// Brief    : Self-checking bench for csr_access_ctrl: directed vector table,
//            hand-written interrupt/reset sequences and random SYSTEM ops
//            checked against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_access_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  string cur = "";

  always #5 clk = ~clk;

  csr_access_ctrl_if #(.DATA_W(32), .CAUSE_W(4)) bus ();

  csr_access_ctrl #(
    .DATA_W    (32),
    .MEPC_ADDR (12'h341),
    .CAUSE_W   (4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    // stimulus
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1;
    bit          valid;
    bit          meip, msip, mtip, mie;
    bit          err_iss, err_resp;
    logic [31:0] rdata;
    // expectations
    bit          ready;
    bit          is_csr, is_trap, is_irq, is_rs1;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [11:0] addr;
    logic [1:0]  op;
    logic [31:0] cpc;
    logic [3:0]  cause;
    bit          wb_v;
    logic [4:0]  wb_rd;
    logic [31:0] wb_d;
    bit          rd_v;
    logic [31:0] rd_pc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s.%s: got %h expected %h", cur, name, act, exp);
    end
  endtask

  function automatic vec_t vin(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] rs1,
                               input logic [2:0] irq, input bit mie, input bit eiss, input bit eresp,
                               input logic [31:0] rdata);
    vec_t v;
    v = '{default: '0};
    v.inst = inst; v.pc = pc; v.rs1 = rs1; v.valid = 1'b1;
    v.meip = irq[2]; v.msip = irq[1]; v.mtip = irq[0]; v.mie = mie;
    v.err_iss = eiss; v.err_resp = eresp; v.rdata = rdata;
    v.ready = 1'b1;
    return v;
  endfunction

  function automatic vec_t ex_csr(input vec_t v, input logic [1:0] op, input logic [11:0] addr,
                                  input logic [31:0] data, input logic [4:0] rd, input bit is_rs1);
    vec_t e = v;
    e.is_csr = 1'b1; e.op = op; e.addr = addr; e.data = data; e.rd = rd; e.is_rs1 = is_rs1; e.cpc = v.pc;
    return e;
  endfunction

  function automatic vec_t ex_trap(input vec_t v, input logic [3:0] cause, input bit irq);
    vec_t e = v;
    e.is_trap = ~irq; e.is_irq = irq; e.cause = cause; e.cpc = v.pc; e.ready = ~irq;
    return e;
  endfunction

  function automatic vec_t ex_wb(input vec_t v, input logic [4:0] rd, input logic [31:0] d);
    vec_t e = v;
    e.wb_v = 1'b1; e.wb_rd = rd; e.wb_d = d;
    return e;
  endfunction

  function automatic vec_t ex_redir(input vec_t v, input logic [31:0] pc);
    vec_t e = v;
    e.rd_v = 1'b1; e.rd_pc = pc;
    return e;
  endfunction

  // Behavioural model: what the controller must do with one offer, from the architectural rules
  function automatic vec_t model(input vec_t v);
    vec_t        e;
    logic [2:0]  f3;
    logic [4:0]  src;
    bit          redirect;
    e = vin(v.inst, v.pc, v.rs1, {v.meip, v.msip, v.mtip}, v.mie, v.err_iss, v.err_resp, v.rdata);
    f3  = v.inst[14:12];
    src = v.inst[19:15];
    redirect = 1'b1;
    e.cpc = v.pc;
    if (v.mie && (v.meip || v.msip || v.mtip)) begin
      e.ready  = 1'b0;
      e.is_irq = 1'b1;
      e.cause  = v.meip ? 4'd11 : (v.msip ? 4'd3 : 4'd7);
    end else if (f3 % 4 != 0) begin
      e.is_csr = 1'b1;
      e.op     = 2'(f3 % 4);
      e.addr   = v.inst[31:20];
      e.rd     = v.inst[11:7];
      e.data   = (f3 >= 4) ? 32'(src) : v.rs1;
      e.is_rs1 = (src == 0);
      redirect = 1'b0;
    end else if (v.inst == 32'h0000_0073) begin
      e.is_trap = 1'b1; e.cause = 4'd11;
    end else if (v.inst == 32'h0010_0073) begin
      e.is_trap = 1'b1; e.cause = 4'd3;
    end else if (v.inst == 32'h3020_0073) begin
      e.is_csr = 1'b1; e.op = 2'b10; e.addr = 12'h341; e.is_rs1 = 1'b1;
    end else begin
      e.is_trap = 1'b1; e.cause = 4'd2;
    end
    if (v.err_iss || v.err_resp) redirect = 1'b1;
    if (redirect) begin
      e.rd_v = 1'b1; e.rd_pc = v.rdata & 32'hFFFF_FFFC;
    end else if (e.rd != 0) begin
      e.wb_v = 1'b1; e.wb_rd = e.rd; e.wb_d = v.rdata;
    end
    return e;
  endfunction

  // Present one offer from IDLE and follow it through ISSUE, RESP and the result cycle
  task automatic do_txn(input vec_t v);
    bus.inst_valid_i = v.valid; bus.inst_i = v.inst; bus.pc_i = v.pc; bus.rs1_data_i = v.rs1;
    bus.irq_meip_i = v.meip; bus.irq_msip_i = v.msip; bus.irq_mtip_i = v.mtip; bus.irq_mie_i = v.mie;
    bus.csr_err_i = 1'b0; bus.csr_data_i = '0;
    #1;
    chk("ready", 32'(bus.inst_ready_o), 32'(v.ready));
    @(posedge clk); #1;
    bus.inst_valid_i = 1'b0;
    bus.irq_meip_i = 1'b0; bus.irq_msip_i = 1'b0; bus.irq_mtip_i = 1'b0; bus.irq_mie_i = 1'b0;
    bus.csr_err_i = v.err_iss;
    chk("is_csr", 32'(bus.csr_is_csr_o), 32'(v.is_csr));
    chk("is_trap", 32'(bus.csr_is_trap_o), 32'(v.is_trap));
    chk("is_irq", 32'(bus.csr_is_interrupt_o), 32'(v.is_irq));
    chk("rd", 32'(bus.csr_rd_o), 32'(v.rd));
    chk("is_rs1", 32'(bus.csr_is_rs1_o), 32'(v.is_rs1));
    chk("data", bus.csr_data_o, v.data);
    chk("addr", 32'(bus.csr_addr_o), 32'(v.addr));
    chk("op", 32'(bus.csr_op_o), 32'(v.op));
    chk("pc", bus.csr_pc_o, v.cpc);
    chk("cause", 32'(bus.csr_cause_o), 32'(v.cause));
    chk("issue_pulses", 32'({bus.wb_valid_o, bus.redirect_valid_o}), 32'd0);
    @(posedge clk); #1;
    bus.csr_err_i = v.err_resp; bus.csr_data_i = v.rdata;
    chk("resp_req_idle", 32'({bus.csr_is_csr_o, bus.csr_is_trap_o, bus.csr_is_interrupt_o}), 32'd0);
    @(posedge clk); #1;
    bus.csr_err_i = 1'b0; bus.csr_data_i = '0;
    chk("wb_valid", 32'(bus.wb_valid_o), 32'(v.wb_v));
    if (v.wb_v) begin
      chk("wb_rd", 32'(bus.wb_rd_o), 32'(v.wb_rd));
      chk("wb_data", bus.wb_data_o, v.wb_d);
    end
    chk("redir_valid", 32'(bus.redirect_valid_o), 32'(v.rd_v));
    if (v.rd_v) chk("redir_pc", bus.redirect_pc_o, v.rd_pc);
    chk("ready_after", 32'(bus.inst_ready_o), 32'd1);
    @(posedge clk); #1;
    chk("pulse_width", 32'({bus.wb_valid_o, bus.redirect_valid_o}), 32'd0);
  endtask

  vec_t tbl[11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.inst_valid_i = 1'b0; bus.inst_i = '0; bus.pc_i = '0; bus.rs1_data_i = '0;
    bus.irq_meip_i = 1'b0; bus.irq_mtip_i = 1'b0; bus.irq_msip_i = 1'b0; bus.irq_mie_i = 1'b0;
    bus.csr_data_i = '0; bus.csr_err_i = 1'b0;

    // Reset state
    cur = "reset";
    #2;
    chk("ready", 32'(bus.inst_ready_o), 32'd1);
    chk("req", 32'({bus.csr_is_csr_o, bus.csr_is_trap_o, bus.csr_is_interrupt_o}), 32'd0);
    chk("addr", 32'(bus.csr_addr_o), 32'd0);
    chk("pulses", 32'({bus.wb_valid_o, bus.redirect_valid_o}), 32'd0);
    chk("redir_pc", bus.redirect_pc_o, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Directed table
    tbl[0]  = ex_wb(ex_csr(vin(32'h305092F3, 32'h100, 32'h80000100, 3'b000, 0, 0, 0, 32'h0),
                           2'b01, 12'h305, 32'h80000100, 5'd5, 0), 5'd5, 32'h0);
    tbl[1]  = ex_csr(vin(32'h30006073, 32'h104, 32'hDEADBEEF, 3'b000, 0, 0, 0, 32'h1888),
                     2'b10, 12'h300, 32'h0, 5'd0, 1);
    tbl[2]  = ex_redir(ex_trap(vin(32'h00000073, 32'h1004, 32'h0, 3'b000, 0, 0, 0, 32'h80000102),
                               4'd11, 0), 32'h80000100);
    tbl[3]  = ex_redir(ex_csr(vin(32'h7C0111F3, 32'h108, 32'h12345678, 3'b000, 0, 1, 0, 32'h200),
                              2'b01, 12'h7C0, 32'h12345678, 5'd3, 0), 32'h200);
    tbl[4]  = ex_redir(ex_csr(vin(32'h30200073, 32'h300, 32'h0, 3'b000, 0, 0, 0, 32'h2008),
                              2'b10, 12'h341, 32'h0, 5'd0, 1), 32'h2008);
    tbl[5]  = ex_redir(ex_trap(vin(32'h00100073, 32'h40, 32'h0, 3'b000, 0, 0, 0, 32'h303),
                               4'd3, 0), 32'h300);
    tbl[6]  = ex_redir(ex_trap(vin(32'h00004073, 32'h44, 32'h0, 3'b000, 0, 0, 0, 32'h500),
                               4'd2, 0), 32'h500);
    tbl[7]  = ex_wb(ex_csr(vin(32'h344FF3F3, 32'h48, 32'h0, 3'b000, 0, 0, 0, 32'hA5A5A5A5),
                           2'b11, 12'h344, 32'h1F, 5'd7, 0), 5'd7, 32'hA5A5A5A5);
    tbl[8]  = ex_redir(ex_trap(vin(32'h305092F3, 32'h4C, 32'h1, 3'b111, 1, 0, 0, 32'h804),
                               4'd11, 1), 32'h804);
    tbl[9]  = ex_wb(ex_csr(vin(32'h305020F3, 32'h50, 32'h0, 3'b111, 0, 0, 0, 32'h77),
                           2'b10, 12'h305, 32'h0, 5'd1, 1), 5'd1, 32'h77);
    tbl[10] = ex_redir(ex_csr(vin(32'h305020F3, 32'h54, 32'h0, 3'b000, 0, 0, 1, 32'h104),
                              2'b10, 12'h305, 32'h0, 5'd1, 1), 32'h104);
    for (int i = 0; i < 11; i++) begin
      cur = $sformatf("vec%0d", i);
      do_txn(tbl[i]);
    end

    // Interrupt beats a same-cycle instruction; the instruction goes in at the next IDLE
    cur = "irq_prio";
    bus.inst_valid_i = 1'b1; bus.inst_i = 32'h305092F3; bus.pc_i = 32'h500; bus.rs1_data_i = 32'h11;
    bus.irq_mtip_i = 1'b1; bus.irq_msip_i = 1'b1; bus.irq_mie_i = 1'b1;
    #1;
    chk("ready", 32'(bus.inst_ready_o), 32'd0);
    @(posedge clk); #1;
    bus.irq_mtip_i = 1'b0; bus.irq_msip_i = 1'b0; bus.irq_mie_i = 1'b0;
    chk("is_irq", 32'(bus.csr_is_interrupt_o), 32'd1);
    chk("cause", 32'(bus.csr_cause_o), 32'd3);
    chk("is_csr", 32'(bus.csr_is_csr_o), 32'd0);
    chk("pc", bus.csr_pc_o, 32'h500);
    @(posedge clk); #1;
    bus.csr_data_i = 32'h900;
    @(posedge clk); #1;
    bus.csr_data_i = '0;
    chk("redir_valid", 32'(bus.redirect_valid_o), 32'd1);
    chk("redir_pc", bus.redirect_pc_o, 32'h900);
    chk("ready_again", 32'(bus.inst_ready_o), 32'd1);
    @(posedge clk); #1;
    bus.inst_valid_i = 1'b0;
    chk("late_is_csr", 32'(bus.csr_is_csr_o), 32'd1);
    chk("late_addr", 32'(bus.csr_addr_o), 32'h305);
    chk("late_data", bus.csr_data_o, 32'h11);
    @(posedge clk); #1;
    bus.csr_data_i = 32'h5;
    @(posedge clk); #1;
    bus.csr_data_i = '0;
    chk("late_wb_valid", 32'(bus.wb_valid_o), 32'd1);
    chk("late_wb_data", bus.wb_data_o, 32'h5);
    chk("late_redir", 32'(bus.redirect_valid_o), 32'd0);
    @(posedge clk); #1;

    // Reset during ISSUE aborts the operation
    cur = "rst_mid";
    bus.inst_valid_i = 1'b1; bus.inst_i = 32'h305092F3; bus.pc_i = 32'h600; bus.rs1_data_i = 32'h55;
    @(posedge clk); #1;
    bus.inst_valid_i = 1'b0;
    chk("issue_is_csr", 32'(bus.csr_is_csr_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("is_csr", 32'(bus.csr_is_csr_o), 32'd0);
    chk("addr", 32'(bus.csr_addr_o), 32'd0);
    chk("data", bus.csr_data_o, 32'd0);
    chk("ready", 32'(bus.inst_ready_o), 32'd1);
    bus.csr_data_i = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("no_pulse", 32'({bus.wb_valid_o, bus.redirect_valid_o}), 32'd0);
      @(posedge clk); #1;
    end
    bus.csr_data_i = '0;

    // Random offers against the model
    for (int i = 0; i < 150; i++) begin
      vec_t        r;
      logic [31:0] u;
      logic [4:0]  rdf, src;
      logic [2:0]  f3;
      int          k;
      cur = $sformatf("rnd%0d", i);
      u   = $urandom;
      r   = vin(32'h0, $urandom, $urandom, 3'b000, 0, ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 7) == 0), $urandom);
      rdf = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      src = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      k   = $urandom_range(0, 9);
      if (k <= 5) begin
        f3 = (k < 3) ? 3'(k + 1) : 3'(k + 2);
        r.inst = {u[31:20], src, f3, rdf, 7'h73};
      end else if (k == 6) r.inst = 32'h0000_0073;
      else if (k == 7)     r.inst = 32'h0010_0073;
      else if (k == 8)     r.inst = 32'h3020_0073;
      else begin
        f3 = u[0] ? 3'b100 : 3'b000;
        r.inst = {u[31:20], src, f3, rdf, 7'h73};
      end
      if ($urandom_range(0, 3) == 0) begin
        u = $urandom;
        r.meip = u[0]; r.msip = u[1]; r.mtip = u[2]; r.mie = u[3];
      end
      do_txn(model(r));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
